// File: rtl/prio_scan_encoder_if.sv
// Request-vector capture and index-stream bundle for prio_scan_encoder.
// slave = the encoder; master = the producer/consumer driving it.
interface prio_scan_encoder_if #(
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] Din;
    logic             Din_valid;
    logic             Din_ready;
    logic [IDX_W-1:0] Dout;
    logic             Dout_valid;
    logic             Dout_ready;
    logic             Dout_last;
    logic [IDX_W:0]   Count;
    logic             Zero_drop;

    modport master (
        output Din, Din_valid, Dout_ready,
        input  Din_ready, Dout, Dout_valid, Dout_last, Count, Zero_drop
    );

    modport slave (
        input  Din, Din_valid, Dout_ready,
        output Din_ready, Dout, Dout_valid, Dout_last, Count, Zero_drop
    );
endinterface

// File: rtl/prio_scan_encoder.sv
// Captures a multi-hot vector and streams each set-bit index in priority order; first index 1 cycle after capture.
// Din_ready is low for the whole scan; Dout_ready low holds the current index and mask unchanged.
module prio_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    prio_scan_encoder_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             zero_drop_q, zero_drop_d;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_last;
    logic [IDX_W:0]   din_pop;
    logic             din_rdy;
    logic             dout_vld;
    logic             accept;
    logic             take;

    assign din_rdy  = (state_q == IDLE) & ~rst;
    assign dout_vld = (state_q == SCAN);
    assign accept   = bus.Din_valid & din_rdy;
    assign take     = dout_vld & bus.Dout_ready;

    // Later loop hits overwrite earlier ones, so scan order sets the priority.
    always_comb begin
        pick_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (mask_q[i]) pick_idx = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (mask_q[i]) pick_idx = IDX_W'(i);
        end
        pick_last = (mask_q != '0) && ((mask_q & (mask_q - WIDTH'(1))) == '0);
    end

    always_comb begin
        din_pop = '0;
        for (int i = 0; i < WIDTH; i++)
            din_pop = din_pop + {{IDX_W{1'b0}}, bus.Din[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            count_q     <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            zero_drop_q <= zero_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && bus.Din != '0) state_d = SCAN;
            SCAN:    if (take && pick_last)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An all-zero vector updates Count and pulses Zero_drop but never touches the mask.
    always_comb begin
        mask_d      = mask_q;
        count_d     = count_q;
        zero_drop_d = 1'b0;
        if (accept) begin
            count_d     = din_pop;
            zero_drop_d = (bus.Din == '0);
            if (bus.Din != '0) mask_d = bus.Din;
        end
        if (take)
            mask_d = mask_q & ~(WIDTH'(1) << pick_idx);
    end

    always_comb begin
        bus.Din_ready  = din_rdy;
        bus.Dout_valid = dout_vld;
        bus.Dout       = dout_vld ? pick_idx : '0;
        bus.Dout_last  = dout_vld & pick_last;
        bus.Count      = count_q;
        bus.Zero_drop  = zero_drop_q;
    end
endmodule

// File: tb/tb_prio_scan_encoder.sv
// Cycle-by-cycle vector table for the 8-bit MSB-first encoder plus a hand sequence for 16-bit LSB-first.
module tb_prio_scan_encoder;
    logic clk;
    logic rst8;
    logic rst16;

    prio_scan_encoder_if #(.WIDTH(8))  b8 ();
    prio_scan_encoder_if #(.WIDTH(16)) b16 ();

    prio_scan_encoder #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_dut8  (.clk(clk), .rst(rst8),  .bus(b8));
    prio_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) u_dut16 (.clk(clk), .rst(rst16), .bus(b16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] din;
        logic       rr;
        logic       er;
        logic       ev;
        logic [2:0] ed;
        logic       el;
        logic [3:0] ec;
        logic       ez;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t v(logic r, logic dv, logic [7:0] din, logic rr,
                               logic er, logic ev, logic [2:0] ed, logic el,
                               logic [3:0] ec, logic ez);
        vec_t t;
        t.rst = r;  t.dv = dv; t.din = din; t.rr = rr;
        t.er = er;  t.ev = ev; t.ed = ed;   t.el = el; t.ec = ec; t.ez = ez;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        //                 rst dv din     rr  rdy vld d  last cnt zd
        tbl.push_back(v(1, 0, 8'h00, 0,  0, 0, 0, 0, 0, 0));  // held in reset
        tbl.push_back(v(0, 1, 8'hA4, 1,  1, 0, 0, 0, 0, 0));  // capture 1010_0100
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 7, 0, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 5, 0, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 2, 1, 3, 0));
        tbl.push_back(v(0, 1, 8'hA4, 0,  1, 0, 0, 0, 3, 0));  // back to idle, recapture
        tbl.push_back(v(0, 0, 8'h00, 0,  0, 1, 7, 0, 3, 0));  // stall x3
        tbl.push_back(v(0, 0, 8'h00, 0,  0, 1, 7, 0, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 0,  0, 1, 7, 0, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 7, 0, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 5, 0, 3, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 2, 1, 3, 0));
        tbl.push_back(v(0, 1, 8'h00, 1,  1, 0, 0, 0, 3, 0));  // all-zero vector
        tbl.push_back(v(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'hFF, 1,  1, 0, 0, 0, 0, 0));  // all ones
        tbl.push_back(v(0, 1, 8'h0F, 1,  0, 1, 7, 0, 8, 0));  // mid-scan Din_valid ignored
        for (int d = 6; d >= 1; d--)
            tbl.push_back(v(0, d > 4, 8'h0F, 1,  0, 1, 3'(d), 0, 8, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 0, 1, 8, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  1, 0, 0, 0, 8, 0));
        tbl.push_back(v(0, 1, 8'hC1, 1,  1, 0, 0, 0, 8, 0));  // reset mid-scan
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 7, 0, 3, 0));
        tbl.push_back(v(1, 1, 8'h80, 1,  0, 1, 6, 0, 3, 0));  // rst wins over Din_valid
        tbl.push_back(v(0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 8'h10, 1,  1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  0, 1, 4, 1, 1, 0));
        tbl.push_back(v(0, 0, 8'h00, 1,  1, 0, 0, 0, 1, 0));

        rst8  = 1'b1;
        rst16 = 1'b1;
        b8.Din = '0;  b8.Din_valid = 1'b0;  b8.Dout_ready = 1'b0;
        b16.Din = '0; b16.Din_valid = 1'b0; b16.Dout_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst8          = tbl[i].rst;
            b8.Din_valid  = tbl[i].dv;
            b8.Din        = tbl[i].din;
            b8.Dout_ready = tbl[i].rr;
            if (i == 0) rst16 = 1'b0;
            #1;
            check($sformatf("row%0d_din_ready",  i), 32'(b8.Din_ready),  32'(tbl[i].er));
            check($sformatf("row%0d_dout_valid", i), 32'(b8.Dout_valid), 32'(tbl[i].ev));
            check($sformatf("row%0d_dout",       i), 32'(b8.Dout),       32'(tbl[i].ed));
            check($sformatf("row%0d_dout_last",  i), 32'(b8.Dout_last),  32'(tbl[i].el));
            check($sformatf("row%0d_count",      i), 32'(b8.Count),      32'(tbl[i].ec));
            check($sformatf("row%0d_zero_drop",  i), 32'(b8.Zero_drop),  32'(tbl[i].ez));
        end

        // 16-bit LSB-first: 16'h8001 emits 0 then 15
        @(negedge clk);
        b16.Din = 16'h8001; b16.Din_valid = 1'b1; b16.Dout_ready = 1'b1;
        #1;
        check("w16_idle_ready", 32'(b16.Din_ready),  32'd1);
        check("w16_idle_valid", 32'(b16.Dout_valid), 32'd0);
        @(negedge clk);
        b16.Din_valid = 1'b0;
        #1;
        check("w16_first_valid", 32'(b16.Dout_valid), 32'd1);
        check("w16_first_dout",  32'(b16.Dout),       32'd0);
        check("w16_first_last",  32'(b16.Dout_last),  32'd0);
        check("w16_count",       32'(b16.Count),      32'd2);
        check("w16_scan_ready",  32'(b16.Din_ready),  32'd0);
        @(negedge clk);
        #1;
        check("w16_second_dout", 32'(b16.Dout),      32'd15);
        check("w16_second_last", 32'(b16.Dout_last), 32'd1);
        @(negedge clk);
        #1;
        check("w16_done_valid", 32'(b16.Dout_valid), 32'd0);
        check("w16_done_ready", 32'(b16.Din_ready),  32'd1);
        check("w16_done_count", 32'(b16.Count),      32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/prio_scan_encoder.md
Name: prio_scan_encoder

Overview:
- Parametrised, registered successor to the 8-to-3 priority encoder.
- Captures a WIDTH-bit request vector and emits the index of every set bit, one per cycle, in priority order over a valid/ready output stream.
- Used wherever a multi-hot vector is serviced sequentially: interrupt pending sets, free-slot lists, grant scanning.
- Input-side ready holds the producer off while a scan is in progress.

Parameters:
- WIDTH, 8, request vector width; must be >= 2.
- IDX_W, $clog2(WIDTH), index output width; derived, not overridden.
- MSB_FIRST, 1, priority order: 1 emits highest set bit first, 0 emits lowest set bit first.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- Din  input  WIDTH  request vector.
- Din_valid  input  1  Din is valid this cycle.
- Din_ready  output  1  block can accept a vector.
- Dout  output  IDX_W  index of current highest-priority remaining bit.
- Dout_valid  output  1  Dout is valid.
- Dout_ready  input  1  consumer takes Dout this cycle.
- Dout_last  output  1  current Dout is the final index of this vector.
- Count  output  IDX_W+1  popcount of the captured vector; stable for the whole scan.
- Zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.

Behaviour:
- Reset: the one clock and a synchronous, active-high rst. While rst is sampled high: state=IDLE, mask=0, Count=0, Zero_drop=0, Dout_valid=0, Dout=0, Dout_last=0.
- Din_ready = (state==IDLE) & ~rst.
- States: IDLE, SCAN.
- IDLE:
  - Accept on Din_valid & Din_ready (cycle N).
  - Din!=0: mask<=Din, Count<=popcount(Din), state<=SCAN. First Dout_valid in cycle N+1 (latency 1).
  - Din==0: mask unchanged, Count<=0, Zero_drop=1 in cycle N+1 only, stay IDLE, Din_ready stays 1.
- SCAN:
  - Dout_valid=1.
  - Dout = index of highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of mask; combinational from the mask register.
  - Dout_last=1 when exactly one bit of mask remains.
  - Handshake (Dout_valid & Dout_ready): clear that bit in mask. If Dout_last, go to IDLE: Din_ready=1 and Dout_valid=0 next cycle.
  - Dout_ready low: Dout, Dout_last and mask hold unchanged; Dout_valid stays 1; no bit lost.
- Din_valid while state==SCAN: ignored, not captured. The producer must hold Din until Din_ready.
- Throughput: a vector with k set bits occupies k+1 cycles minimum (1 capture + k emits); no overlap of capture with the last emit.
- Outputs in IDLE: Dout=0, Dout_last=0. Count keeps the last captured value until the next accept or reset.
- Count width is IDX_W+1 so an all-ones vector reports WIDTH exactly. No truncation.
- Reset mid-scan: remaining indices are discarded. The cycle after rst is sampled high, Dout_valid=0, mask=0, Count=0. Din_ready=1 the cycle after rst is sampled low.
- Simultaneous rst and Din_valid: rst wins, no capture.
- Dout_ready high while Dout_valid=0: no effect.

Test Plan:
- WIDTH=8, MSB_FIRST=1, Din=8'b1010_0100 accepted, Dout_ready=1 -> Dout 7,5,2 on consecutive cycles; Dout_last only with 2; Count=3; Din_ready=1 the cycle after 2 is taken.
- Same vector, Dout_ready held low 3 cycles at first emit -> Dout=7, Dout_valid=1 held all 3 cycles; then 5,2 follow with no skip.
- Din=8'h00 accepted -> Zero_drop pulses exactly 1 cycle, Dout_valid never asserts, Count=0, Din_ready stays 1.
- Din=8'hFF -> 8 emits 7..0, Count=4'd8, Dout_last on index 0. Din_valid pulsed with a new vector mid-scan is not captured.
- WIDTH=16, MSB_FIRST=0, Din=16'h8001 -> Dout 0 then 15, Dout_last on 15, Count=2.
- Din=8'b1100_0001, rst asserted 1 cycle after the first emit (7) is taken -> next cycle Dout_valid=0, Count=0. After rst drops, Din_ready=1 and a new vector 8'h10 yields a single Dout=4 with Dout_last=1.
